// File: rtl/rom_arb_pkg.sv
// Shared widths and types for the ROM arbiter: ROM bus typedefs and the
// return-path tag that follows each issued read.
package rom_arb_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last grant,
// wrapping mod N_REQ, and remembers the winner as the next search origin.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [IDX_W-1:0] ptr_q, ptr_d, cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    // Explicit modulo keeps the wrap correct for non-power-of-2 N_REQ.
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((int'(ptr_q) + off) % N_REQ);
      if (!any_grant && !reset && req[cand]) begin
        any_grant = 1'b1;
        grant_idx = cand;
      end
    end
    if (any_grant) grant[grant_idx] = 1'b1;
    ptr_d = any_grant ? grant_idx : ptr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= IDX_W'(N_REQ - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM between N_REQ requesters: round-robin issue of
// one read per clock, with a tag pipeline steering rom_q back to its owner.
module rom_arbiter #(
  parameter int N_REQ        = 4,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = rom_arb_pkg::ADDR_W,
  parameter int DATA_W       = rom_arb_pkg::DATA_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
  output logic [N_REQ-1:0]              ack,
  output logic [N_REQ-1:0]              rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             rom_address,
  input  logic [DATA_W-1:0]             rom_q
);
  import rom_arb_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any_grant;
  tag_t             tag_d;
  tag_t             tag_q [READ_LATENCY];

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Issue stage: grant and ROM address in the same cycle as the request.
  assign ack         = grant;
  assign rom_address = any_grant ? req_addr[grant_idx] : '0;

  always_comb begin
    tag_d.valid = any_grant;
    tag_d.idx   = 3'(grant_idx);
  end

  // Tag stages: only valid bits are reset; indices are don't-care when invalid.
  always_ff @(posedge clock) begin
    tag_q[0].idx <= tag_d.idx;
    for (int s = 1; s < READ_LATENCY; s++) tag_q[s].idx <= tag_q[s-1].idx;
    if (reset) begin
      for (int s = 0; s < READ_LATENCY; s++) tag_q[s].valid <= 1'b0;
    end else begin
      tag_q[0].valid <= tag_d.valid;
      for (int s = 1; s < READ_LATENCY; s++) tag_q[s].valid <= tag_q[s-1].valid;
    end
  end

  // Return stage: decode the oldest tag; rom_q is passed straight through.
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rvalid[i] = !reset && tag_q[READ_LATENCY-1].valid &&
                  (tag_q[READ_LATENCY-1].idx == 3'(i));
    end
  end

  assign rdata = rom_q;

endmodule
